// File: rtl/regfile_32x64_pkg.sv
// Shared CPU types and constants for the integer register file.
// Also provides a one-hot check used by the write-select error flag.
package regfile_32x64_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    localparam reg_addr_t XZR = 5'd31;

    function automatic logic is_onehot(input logic [REG_COUNT-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < REG_COUNT; i++) begin
            cnt += {31'd0, v[i]};
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/regfile_32x64_reg_en_64.sv
// WIDTH-bit storage register with load enable and async active-high clear.
// One instance backs each architectural register X0..X30.
module reg_en_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (en_i) begin
            val_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/regfile_32x64.sv
// 32x64 register file: two combinational read ports, one one-hot write port.
// X31 is hard-wired zero; sel_error latches any non-one-hot write attempt.
import regfile_32x64_pkg::*;

module regfile_32x64 #(
    parameter int WIDTH  = DATA_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [REG_COUNT-1:0] WriteSel,
    input  logic [WIDTH-1:0]     WriteData,
    input  reg_addr_t            ReadRegister1,
    input  reg_addr_t            ReadRegister2,
    output logic [WIDTH-1:0]     ReadData1,
    output logic [WIDTH-1:0]     ReadData2,
    output logic                 sel_error
);

    logic [WIDTH-1:0] x_q [REG_COUNT];
    logic             sel_err_q;
    logic             sel_err_d;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT - 1; gi++) begin : g_reg
            reg_en_64 #(
                .WIDTH(WIDTH)
            ) u_reg (
                .clk_i(clk),
                .clr_i(reset),
                .en_i (RegWrite & WriteSel[gi]),
                .d_i  (WriteData),
                .q_o  (x_q[gi])
            );
        end
    endgenerate

    // XZR has no storage; its mux leg is a constant zero.
    assign x_q[REG_COUNT-1] = '0;

    reg_addr_t        raddr [2];
    logic [WIDTH-1:0] rdata [2];

    assign raddr[0] = ReadRegister1;
    assign raddr[1] = ReadRegister2;

    genvar gp;
    generate
        for (gp = 0; gp < 2; gp++) begin : g_rd
            logic byp;
            logic zero;
            assign zero = reset || (raddr[gp] == XZR);
            assign byp  = BYPASS && RegWrite && WriteSel[raddr[gp]];
            assign rdata[gp] = zero ? '0
                             : byp  ? WriteData
                             : x_q[raddr[gp]];
        end
    endgenerate

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];

    always_comb begin
        sel_err_d = sel_err_q;
        if (RegWrite && !is_onehot(WriteSel)) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_error = sel_err_q;

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64 (BYPASS=1 main DUT, BYPASS=0 twin).
// Expected read values come from a bench-side register model via a queue.
module tb_regfile_32x64;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [31:0] WriteSel;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        sel_error;
    logic [63:0] nb_ReadData1;
    logic [63:0] nb_ReadData2;
    logic        nb_sel_error;

    int errors;
    int checks;

    logic [63:0] mdl [32];
    logic        exp_err;

    typedef struct {
        int          port;
        logic [4:0]  addr;
        logic [63:0] exp;
    } exp_t;

    exp_t sb [$];

    regfile_32x64 #(
        .WIDTH (64),
        .BYPASS(1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteSel     (WriteSel),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .sel_error    (sel_error)
    );

    regfile_32x64 #(
        .WIDTH (64),
        .BYPASS(1'b0)
    ) dut_nb (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteSel     (WriteSel),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (nb_ReadData1),
        .ReadData2    (nb_ReadData2),
        .sel_error    (nb_sel_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        exp_err = 1'b0;
    endtask

    task automatic read_pair(input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        logic [63:0] act;
        e.port = 1; e.addr = a1; e.exp = (a1 == 5'd31) ? 64'd0 : mdl[a1];
        sb.push_back(e);
        e.port = 2; e.addr = a2; e.exp = (a2 == 5'd31) ? 64'd0 : mdl[a2];
        sb.push_back(e);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = (e.port == 1) ? ReadData1 : ReadData2;
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL read_p%0d_x%0d: got %h want %h",
                         e.port, e.addr, act, e.exp);
            end
        end
    endtask

    task automatic check_err(input string name);
        checks++;
        if (sel_error !== exp_err) begin
            errors++;
            $display("FAIL %s: sel_error got %b want %b", name, sel_error, exp_err);
        end
    endtask

    task automatic do_write(input logic we, input logic [31:0] sel,
                            input logic [63:0] d);
        @(negedge clk);
        RegWrite  = we;
        WriteSel  = sel;
        WriteData = d;
        @(posedge clk);
        #1;
        if (we) begin
            for (int i = 0; i < 31; i++) if (sel[i]) mdl[i] = d;
            if ($countones(sel) != 1) exp_err = 1'b1;
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_err("reset_sel_error");
        for (int i = 0; i < 31; i++) read_pair(5'(i), 5'(30 - i));
        RegWrite  = 1'b1;
        WriteSel  = 32'h0000_0004;
        WriteData = 64'hCAFE_0000_0000_CAFE;
        ReadRegister1 = 5'd2;
        #1;
        checks++;
        if (ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_bypass: got %h want %h", ReadData1, 64'd0);
        end
        RegWrite = 1'b0;
        WriteSel = 32'd0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        read_pair(5'd2, 5'd0);
    endtask

    task automatic test_basic();
        do_write(1'b1, 32'h0000_0020, 64'hDEAD_BEEF_0123_4567);
        read_pair(5'd5, 5'd4);
        check_err("basic_sel_error");
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) begin
            do_write(1'b1, 32'd1 << i, 64'(i) * 64'h0101_0101_0101_0101);
        end
        for (int i = 0; i < 32; i++) read_pair(5'(i), 5'(31 - i));
        check_err("sweep_sel_error");
    endtask

    task automatic test_gating();
        do_write(1'b0, 32'h0000_0008, 64'hFFFF_FFFF_FFFF_FFFF);
        read_pair(5'd3, 5'd3);
        check_err("gating_sel_error");
    endtask

    task automatic test_bypass();
        do_write(1'b1, 32'd1 << 7, 64'h11);
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteSel      = 32'd1 << 7;
        WriteData     = 64'h22;
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd31;
        #1;
        checks++;
        if (ReadData1 !== 64'h22) begin
            errors++;
            $display("FAIL bypass1_pre: got %h want %h", ReadData1, 64'h22);
        end
        checks++;
        if (nb_ReadData1 !== 64'h11) begin
            errors++;
            $display("FAIL bypass0_pre: got %h want %h", nb_ReadData1, 64'h11);
        end
        @(posedge clk);
        #1;
        mdl[7] = 64'h22;
        checks++;
        if (ReadData1 !== 64'h22) begin
            errors++;
            $display("FAIL bypass1_post: got %h want %h", ReadData1, 64'h22);
        end
        checks++;
        if (nb_ReadData1 !== 64'h22) begin
            errors++;
            $display("FAIL bypass0_post: got %h want %h", nb_ReadData1, 64'h22);
        end
        @(negedge clk);
        WriteSel  = 32'd1 << 31;
        WriteData = 64'h33;
        ReadRegister1 = 5'd31;
        #1;
        checks++;
        if (ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL bypass_xzr: got %h want %h", ReadData1, 64'd0);
        end
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
        read_pair(5'd31, 5'd7);
        check_err("bypass_sel_error");
    endtask

    task automatic test_sel_error();
        do_write(1'b1, 32'h0000_0003, 64'hA5);
        read_pair(5'd0, 5'd1);
        check_err("multihot_sel_error");
        do_write(1'b1, 32'h0000_0400, 64'h5A);
        read_pair(5'd10, 5'd2);
        check_err("sticky_sel_error");
        do_write(1'b1, 32'h0000_0000, 64'h77);
        read_pair(5'd0, 5'd10);
        check_err("zerohot_sel_error");
    endtask

    task automatic test_back_to_back();
        do_write(1'b1, 32'd1 << 12, 64'h1212_1212_0000_0001);
        do_write(1'b1, 32'd1 << 13, 64'h1313_1313_0000_0002);
        do_write(1'b1, 32'd1 << 12, 64'h1212_1212_0000_0003);
        read_pair(5'd12, 5'd13);
        read_pair(5'd13, 5'd13);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteSel      = 32'd0;
        WriteData     = 64'd0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_basic();
        test_sweep();
        test_gating();
        test_bypass();
        test_back_to_back();
        test_sel_error();
        test_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
